timepulse_gen: RTL and testbench
================================

# timepulse_gen

Parametrised, fully synchronous timing-pulse generator for the CPU core. It divides `SIM_CLK` into a one-hot phase ring and a one-hot time-pulse ring (`T01..Tn`). It also provides:
- GOJAM restart sequencing,
- memory-stop and single-step control,
- a scaler counting memory cycles,
- overflow/underflow strobing of the write bus sign bits.

It replaces the fixed 12-pulse, 4-phase discrete-gate timer in new builds, where the pulse count, phase count and clock division differ per configuration.

## Interface
Parameters:
- `NUM_TP`, 12: time pulses per memory cycle (≥2)
- `PH_PER_TP`, 4: phases per time pulse (≥2)
- `DIV`, 1: `SIM_CLK` cycles per phase (≥1)
- `FS_WIDTH`, 16: scaler width
- `OVF_PH`, 2: phase index (0-based) at which the overflow strobe fires

Ports:
- `SIM_CLK`  in  1  system clock
- `SIM_RST`  in  1  reset, asynchronous, active-low
- `SBY`  in  1  standby; freezes all state while 1
- `GOJ_REQ`  in  1  restart request, level-sensitive
- `MSTP`  in  1  memory-stop mode enable
- `MSTRT`  in  1  step request, rising-edge detected
- `WL15`, `WL16`  in  1 each  write-bus sign bits
- `T`  out  `NUM_TP`  one-hot time pulse; bit 0 = T01
- `PHS`  out  `PH_PER_TP`  one-hot phase within the current time pulse
- `TP_STB`  out  1  high on the first clock of each time pulse
- `MCT_DONE`  out  1  high on the last clock of the last time pulse
- `GOJAM`  out  1  restart in progress
- `STOPPED`  out  1  generator halted by `MSTP`
- `FS`  out  `FS_WIDTH`  memory-cycle count
- `OVF`, `UNF`  out  1 each  registered overflow/underflow flags

## Operation
- Counters: `div_cnt` (0..`DIV`-1), phase index `ph` (0..`PH_PER_TP`-1), pulse index `tp` (0..`NUM_TP`-1).
- Advance rule: `ph` advances when `div_cnt` wraps; `tp` advances when `ph` wraps.
- States: `GOJ`, `RUN`, `STOP`.
- Reset: state `GOJ`; `tp`=`NUM_TP`-1, `ph`=0, `div_cnt`=0.
- Reset output values: `T`=one-hot bit `NUM_TP`-1, `PHS`=one-hot bit 0, `GOJAM`=1, `TP_STB`=1, `MCT_DONE`=0, `STOPPED`=0, `FS`=0, `OVF`=`UNF`=0. Only `GOJ` exits via the full-pulse path below.
- `GOJ`:
  - Runs exactly one full time pulse on `T[NUM_TP-1]` with `GOJAM`=1.
  - At its last clock, goes to `RUN` with `tp`=0.
  - `MCT_DONE` is not asserted and `FS` does not increment.
- `RUN`:
  - Normal counting.
  - At the `MCT_DONE` clock, `FS` increments (modulo 2^`FS_WIDTH`).
  - At that same clock: if `MSTP`=1, go to `STOP`; otherwise `tp` wraps to 0.
- `STOP`:
  - `T`=0, `PHS`=0, `STOPPED`=1; counters hold at `tp`=0, `ph`=0, `div_cnt`=0.
  - A detected rising edge of `MSTRT` (registered, so one clock of latency) returns the block to `RUN` at T01. It then runs one full cycle and stops again if `MSTP` is still 1.
  - `MSTP` falling while in `STOP` returns the block to `RUN` on the next clock.
- `GOJ_REQ`=1 in any state (including mid-pulse or `STOP`) forces `GOJ` on the next clock: counters reload as at reset and `GOJAM`=1. A held request keeps re-entering `GOJ`, so `GOJAM` stays 1 until one full pulse completes after release.
- `SBY`=1:
  - Clock-enables every register off, including the `MSTRT` edge detector; outputs hold their values.
  - `GOJ_REQ` is ignored while `SBY`=1; it takes effect if still high on the first clock after `SBY` falls.
- Overflow: on the clock where `ph`=`OVF_PH` and `div_cnt`=0 in `RUN`:
  - `OVF` ← `WL15 & ~WL16`
  - `UNF` ← `~WL15 & WL16`
  - Flags hold between strobes; `GOJ` clears both.
- Priority: `SIM_RST` > `SBY` > `GOJ_REQ` > step/stop > count.

## Timing
- All outputs are registered.
- Memory cycle = `NUM_TP`×`PH_PER_TP`×`DIV` clocks; defaults give 48.
- `TP_STB` is high for exactly one clock per time pulse, including in `GOJ`.
- `MCT_DONE` is high for exactly one clock per `RUN` cycle, coincident with `T[NUM_TP-1]` and `PHS[PH_PER_TP-1]`.
- Latencies:
  - `GOJ_REQ` to `GOJAM`=1: 1 clock.
  - `GOJAM`: exactly `PH_PER_TP`×`DIV` clocks after the request drops.
  - `MSTRT` edge to `T01`: 2 clocks (sync + transition).
  - `MSTP` low to `T01`: 1 clock.
- Deasserting `SIM_RST` mid-cycle restarts at `GOJ`; there is no partial cycle.

## Structure
- Shared package `timer_pkg`: state enum (`GOJ`, `RUN`, `STOP`), clog2-derived width localparams, overflow decode function.
- Sub-module `phase_divider` (`div_cnt` + phase ring, with enable and load inputs; outputs the `ph` wrap and `PHS`). Instantiated once; the top level holds the pulse ring, FSM, scaler and flags.

## Test plan
- Defaults, release reset, idle inputs → `GOJAM`=1 for clocks 0–3 with `T`=`12'h800`, then T01 at clock 4; first `MCT_DONE` at clock 51; `FS`=1 at clock 52.
- `MSTP`=1 from start → after the first `MCT_DONE`, `STOPPED`=1 and `T`=0. One `MSTRT` pulse → `T01` 2 clocks later, exactly 48 clocks run, `STOPPED`=1 again, `FS`=2.
- `GOJ_REQ` one-clock pulse while in T07 phase 1 → next clock `GOJAM`=1, `T`=`12'h800`, `PHS`=1, `OVF`/`UNF`=0; T01 4 clocks later; `FS` unchanged.
- `WL15`=1, `WL16`=0 held → `OVF`=1 one clock after the phase-2 clock of T01. Switch to `WL15`=0, `WL16`=1 → `UNF`=1 and `OVF`=0 at the next strobe, one time pulse later.
- `SBY`=1 for 10 clocks mid-T05, with `GOJ_REQ` pulsed inside the window → all outputs frozen and the request ignored; counting resumes at the same phase afterwards.
- Configuration `NUM_TP`=6, `PH_PER_TP`=3, `DIV`=2 → cycle of 36 clocks and `TP_STB` every 6 clocks; `FS_WIDTH`=2 wraps 3→0 on the 4th `MCT_DONE`.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timing-pulse generator.
//   - tp_state_e : generator state (restart, counting, memory-stopped)
//   - cw()       : counter width for a modulus, never below one bit
//   - ovf_decode : write-bus sign bits -> {overflow, underflow}
package timer_pkg;

  typedef enum logic [1:0] {
    GOJ  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } tp_state_e;

  // A modulus of 1 still needs a 1-bit register so the ports stay legal.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_TP    = 12;
  localparam int DEF_PH_PER_TP = 4;
  localparam int DEF_DIV       = 1;
  localparam int DEF_TP_W      = cw(DEF_NUM_TP);
  localparam int DEF_PH_W      = cw(DEF_PH_PER_TP);
  localparam int DEF_DV_W      = cw(DEF_DIV);

  // Sign bits disagreeing means the sum left the representable range:
  // 01 in {WL16,WL15} is positive overflow, 10 is negative underflow.
  function automatic logic [1:0] ovf_decode(input logic wl15, input logic wl16);
    return {wl15 & ~wl16, ~wl15 & wl16};
  endfunction

endpackage

// File: rtl/timepulse_gen_phase_divider.sv
// Clock divider plus phase ring for one time pulse.
//   clk/rst_n : clock, async active-low reset
//   en        : register clock enable (low = freeze everything)
//   load      : reload counters to phase 0 / div 0 (restart)
//   step      : advance the counters (low = hold)
//   blank     : next PHS value forced to all-zero (stopped)
//   ph/div_cnt: current phase index and divider count
//   ph_nxt/div_nxt : values the counters take at the next enabled edge
//   wrap      : last clock of the last phase while stepping
//   phs       : registered one-hot phase
module phase_divider import timer_pkg::*; #(
  parameter int PH_PER_TP = 4,
  parameter int DIV       = 1,
  localparam int PH_W     = cw(PH_PER_TP),
  localparam int DV_W     = cw(DIV)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic                 step,
  input  logic                 blank,
  output logic [PH_W-1:0]      ph,
  output logic [DV_W-1:0]      div_cnt,
  output logic [PH_W-1:0]      ph_nxt,
  output logic [DV_W-1:0]      div_nxt,
  output logic                 wrap,
  output logic [PH_PER_TP-1:0] phs
);

  localparam logic [PH_PER_TP-1:0] PHS_RST = {{(PH_PER_TP-1){1'b0}}, 1'b1};

  logic [DV_W-1:0]      div_q, div_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [PH_PER_TP-1:0] phs_q, phs_d;
  logic                 div_last, ph_last;

  assign div_last = (div_q == DV_W'(DIV - 1));
  assign ph_last  = (ph_q == PH_W'(PH_PER_TP - 1));
  assign wrap     = step & div_last & ph_last;

  always_comb begin
    div_d = div_q;
    ph_d  = ph_q;
    if (load) begin
      div_d = '0;
      ph_d  = '0;
    end else if (step) begin
      div_d = div_last ? '0 : div_q + 1'b1;
      if (div_last) ph_d = ph_last ? '0 : ph_q + 1'b1;
    end
    // PHS is registered from the next phase so it lines up with the counters.
    phs_d = '0;
    if (!blank) phs_d[ph_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      ph_q  <= '0;
      phs_q <= PHS_RST;
    end else if (en) begin
      div_q <= div_d;
      ph_q  <= ph_d;
      phs_q <= phs_d;
    end
  end

  assign ph      = ph_q;
  assign div_cnt = div_q;
  assign ph_nxt  = ph_d;
  assign div_nxt = div_d;
  assign phs     = phs_q;

endmodule

// File: rtl/timepulse_gen.sv
// Timing-pulse generator: divides SIM_CLK into a one-hot phase ring (PHS)
// and a one-hot time-pulse ring (T, bit 0 = T01), with restart (GOJAM)
// sequencing, memory-stop / single-step, a memory-cycle scaler and
// registered overflow/underflow flags sampled from the write-bus sign bits.
//   SIM_CLK, SIM_RST : clock, async active-low reset
//   SBY              : standby, freezes every register
//   GOJ_REQ          : level restart request
//   MSTP, MSTRT      : memory-stop enable, step request (rising edge)
//   WL15, WL16       : write-bus sign bits
//   T, PHS           : one-hot pulse / phase (all-zero while stopped)
//   TP_STB, MCT_DONE : first clock of a pulse, last clock of a cycle
//   GOJAM, STOPPED   : restart in progress, halted by MSTP
//   FS               : memory-cycle count
//   OVF, UNF         : overflow / underflow flags
module timepulse_gen import timer_pkg::*; #(
  parameter int NUM_TP    = 12,
  parameter int PH_PER_TP = 4,
  parameter int DIV       = 1,
  parameter int FS_WIDTH  = 16,
  parameter int OVF_PH    = 2
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 SBY,
  input  logic                 GOJ_REQ,
  input  logic                 MSTP,
  input  logic                 MSTRT,
  input  logic                 WL15,
  input  logic                 WL16,
  output logic [NUM_TP-1:0]    T,
  output logic [PH_PER_TP-1:0] PHS,
  output logic                 TP_STB,
  output logic                 MCT_DONE,
  output logic                 GOJAM,
  output logic                 STOPPED,
  output logic [FS_WIDTH-1:0]  FS,
  output logic                 OVF,
  output logic                 UNF
);

  localparam int TP_W = cw(NUM_TP);
  localparam int PH_W = cw(PH_PER_TP);
  localparam int DV_W = cw(DIV);
  localparam logic [NUM_TP-1:0] T_RST = {1'b1, {(NUM_TP-1){1'b0}}};

  tp_state_e             state_q, state_d;
  logic [TP_W-1:0]       tp_q, tp_d;
  logic [NUM_TP-1:0]     t_q, t_d;
  logic                  tp_stb_q, tp_stb_d;
  logic                  mct_done_q, mct_done_d;
  logic                  gojam_q, gojam_d;
  logic                  stopped_q, stopped_d;
  logic [FS_WIDTH-1:0]   fs_q, fs_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  mstrt_q;
  logic                  mstrt_edge_q, mstrt_edge_d;

  logic                  en, cnt_en, wrap, strobe;
  logic [PH_W-1:0]       ph, ph_nxt;
  logic [DV_W-1:0]       div_cnt, div_nxt;
  logic [1:0]            flags;

  assign en     = ~SBY;
  // Counters only move in GOJ/RUN; in STOP they sit at zero so the
  // return to RUN lands exactly on T01 phase 0.
  assign cnt_en = (state_q != STOP);

  phase_divider #(
    .PH_PER_TP (PH_PER_TP),
    .DIV       (DIV)
  ) u_phdiv (
    .clk     (SIM_CLK),
    .rst_n   (SIM_RST),
    .en      (en),
    .load    (GOJ_REQ),
    .step    (cnt_en),
    .blank   (state_d == STOP),
    .ph      (ph),
    .div_cnt (div_cnt),
    .ph_nxt  (ph_nxt),
    .div_nxt (div_nxt),
    .wrap    (wrap),
    .phs     (PHS)
  );

  assign strobe = (state_q == RUN) && (ph == PH_W'(OVF_PH)) && (div_cnt == '0);
  assign flags  = ovf_decode(WL15, WL16);

  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    if (GOJ_REQ) begin
      state_d = GOJ;
      tp_d    = TP_W'(NUM_TP - 1);
    end else begin
      unique case (state_q)
        GOJ: if (wrap) begin
          state_d = RUN;
          tp_d    = '0;
        end
        RUN: if (wrap) begin
          if (tp_q == TP_W'(NUM_TP - 1)) begin
            tp_d = '0;
            if (MSTP) state_d = STOP;
          end else begin
            tp_d = tp_q + 1'b1;
          end
        end
        STOP: if (mstrt_edge_q || !MSTP) state_d = RUN;
        default: state_d = GOJ;
      endcase
    end
  end

  // Registered outputs are decoded from next-state values so every output
  // describes the same clock as the counters it belongs to.
  always_comb begin
    t_d = '0;
    if (state_d != STOP) t_d[tp_d] = 1'b1;
    gojam_d    = (state_d == GOJ);
    stopped_d  = (state_d == STOP);
    tp_stb_d   = (state_d != STOP) && (ph_nxt == '0) && (div_nxt == '0);
    mct_done_d = (state_d == RUN) && (tp_d == TP_W'(NUM_TP - 1)) &&
                 (ph_nxt == PH_W'(PH_PER_TP - 1)) && (div_nxt == DV_W'(DIV - 1));
    fs_d       = fs_q + FS_WIDTH'(mct_done_q);
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (state_d == GOJ) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (strobe) begin
      ovf_d = flags[1];
      unf_d = flags[0];
    end
    // An edge outside STOP is simply dropped on the next clock.
    mstrt_edge_d = MSTRT & ~mstrt_q;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q      <= GOJ;
      tp_q         <= TP_W'(NUM_TP - 1);
      t_q          <= T_RST;
      tp_stb_q     <= 1'b1;
      mct_done_q   <= 1'b0;
      gojam_q      <= 1'b1;
      stopped_q    <= 1'b0;
      fs_q         <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      mstrt_q      <= 1'b0;
      mstrt_edge_q <= 1'b0;
    end else if (en) begin
      state_q      <= state_d;
      tp_q         <= tp_d;
      t_q          <= t_d;
      tp_stb_q     <= tp_stb_d;
      mct_done_q   <= mct_done_d;
      gojam_q      <= gojam_d;
      stopped_q    <= stopped_d;
      fs_q         <= fs_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      mstrt_q      <= MSTRT;
      mstrt_edge_q <= mstrt_edge_d;
    end
  end

  assign T        = t_q;
  assign TP_STB   = tp_stb_q;
  assign MCT_DONE = mct_done_q;
  assign GOJAM    = gojam_q;
  assign STOPPED  = stopped_q;
  assign FS       = fs_q;
  assign OVF      = ovf_q;
  assign UNF      = unf_q;

endmodule

// File: tb/tb_timepulse_gen.sv
// Directed bench for timepulse_gen: default configuration (A) exercised
// through restart, overflow flags, restart mid-cycle, standby, memory-stop,
// single-step and held restart; a small configuration (B) checked for
// cycle length, strobe spacing and scaler wrap.
module tb_timepulse_gen;

  logic clk = 1'b0, rst_n = 1'b0, rst_b = 1'b0;
  always #5 clk = ~clk;

  logic sby, goj_req, mstp, mstrt, wl15, wl16;
  logic [11:0] t;
  logic [3:0]  phs;
  logic        tp_stb, mct, gojam, stopped, ovf, unf;
  logic [15:0] fs;

  logic [5:0]  t_b;
  logic [2:0]  phs_b;
  logic        tp_stb_b, mct_b, gojam_b, stopped_b, ovf_b, unf_b;
  logic [1:0]  fs_b;

  timepulse_gen u_a (
    .SIM_CLK (clk), .SIM_RST (rst_n), .SBY (sby), .GOJ_REQ (goj_req),
    .MSTP (mstp), .MSTRT (mstrt), .WL15 (wl15), .WL16 (wl16),
    .T (t), .PHS (phs), .TP_STB (tp_stb), .MCT_DONE (mct), .GOJAM (gojam),
    .STOPPED (stopped), .FS (fs), .OVF (ovf), .UNF (unf)
  );

  timepulse_gen #(.NUM_TP(6), .PH_PER_TP(3), .DIV(2), .FS_WIDTH(2), .OVF_PH(1)) u_b (
    .SIM_CLK (clk), .SIM_RST (rst_b), .SBY (1'b0), .GOJ_REQ (1'b0),
    .MSTP (1'b0), .MSTRT (1'b0), .WL15 (1'b1), .WL16 (1'b0),
    .T (t_b), .PHS (phs_b), .TP_STB (tp_stb_b), .MCT_DONE (mct_b), .GOJAM (gojam_b),
    .STOPPED (stopped_b), .FS (fs_b), .OVF (ovf_b), .UNF (unf_b)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at clock %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int nstb, nmct, nrun;
    sby = 0; goj_req = 0; mstp = 0; mstrt = 0; wl15 = 1; wl16 = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1; cyc = 0;

    // reset state
    chk("rst_T", t, 12'h800);      chk("rst_PHS", phs, 4'h1);
    chk("rst_GOJAM", gojam, 1);    chk("rst_TP_STB", tp_stb, 1);
    chk("rst_MCT", mct, 0);        chk("rst_STOPPED", stopped, 0);
    chk("rst_FS", fs, 0);          chk("rst_OVF", ovf, 0);
    chk("rst_UNF", unf, 0);

    // restart pulse occupies clocks 0-3
    for (int c = 1; c < 4; c++) begin
      go(c); chk("goj_T", t, 12'h800); chk("goj_GOJAM", gojam, 1); chk("goj_STB", tp_stb, 0);
    end
    go(4); chk("t01_T", t, 12'h001); chk("t01_GOJAM", gojam, 0);
    chk("t01_STB", tp_stb, 1); chk("t01_PHS", phs, 4'h1);

    // overflow strobe at T01 phase 2 (clock 6), visible at clock 7
    go(6); chk("ovf_pre_PHS", phs, 4'h4); chk("ovf_pre", ovf, 0);
    go(7); chk("ovf_set", ovf, 1); chk("ovf_set_unf", unf, 0);
    wl15 = 0; wl16 = 1;
    go(10); chk("ovf_hold", ovf, 1);
    go(11); chk("unf_set", unf, 1); chk("unf_set_ovf", ovf, 0);
    wl16 = 0;
    go(15); chk("flags_clr_unf", unf, 0); chk("flags_clr_ovf", ovf, 0);

    // strobe / cycle-done counts through the rest of the first cycle
    nstb = 0; nmct = 0;
    for (int c = 16; c <= 51; c++) begin
      go(c); nstb += int'(tp_stb); nmct += int'(mct);
    end
    chk("stb_count", nstb, 9); chk("mct_count", nmct, 1);
    chk("mct_T", t, 12'h800); chk("mct_PHS", phs, 4'h8); chk("mct_last", mct, 1);
    go(52); chk("fs1", fs, 1); chk("cyc2_T", t, 12'h001); chk("cyc2_MCT", mct, 0);

    // restart mid-cycle at T07 phase 1 (clock 77)
    wl15 = 1; wl16 = 0;
    go(77); chk("t07_T", t, 12'h040); chk("t07_PHS", phs, 4'h2); chk("t07_OVF", ovf, 1);
    goj_req = 1;
    go(78); goj_req = 0;
    chk("rq_GOJAM", gojam, 1); chk("rq_T", t, 12'h800); chk("rq_PHS", phs, 4'h1);
    chk("rq_OVF", ovf, 0); chk("rq_UNF", unf, 0); chk("rq_FS", fs, 1);
    go(81); chk("rq_end_GOJAM", gojam, 1);
    go(82); chk("rq_T01", t, 12'h001); chk("rq_T01_GOJAM", gojam, 0); chk("rq_T01_FS", fs, 1);

    // standby for 10 clocks in T05 phase 1 with a restart request inside
    go(99); chk("sby_pre_T", t, 12'h010); chk("sby_pre_PHS", phs, 4'h2);
    sby = 1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) goj_req = 1;
      if (k == 5) goj_req = 0;
      tick();
      chk("sby_T", t, 12'h010); chk("sby_PHS", phs, 4'h2); chk("sby_GOJAM", gojam, 0);
    end
    sby = 0;
    go(110); chk("sby_post_PHS", phs, 4'h4); chk("sby_post_T", t, 12'h010);
    chk("sby_post_GOJAM", gojam, 0);

    // memory stop at the end of this cycle (MCT_DONE at clock 139)
    mstp = 1;
    go(138); chk("stp_pre_MCT", mct, 0);
    go(139); chk("stp_MCT", mct, 1);
    go(140); chk("stp_STOPPED", stopped, 1); chk("stp_T", t, 0); chk("stp_PHS", phs, 0);
    chk("stp_FS", fs, 2); chk("stp_STB", tp_stb, 0);
    go(145); chk("stp_hold", stopped, 1);

    // single step: edge at 145 -> T01 at 147, one full cycle, stop again
    mstrt = 1;
    go(146); mstrt = 0; chk("step_sync", stopped, 1);
    go(147); chk("step_T01", t, 12'h001); chk("step_STOPPED", stopped, 0);
    chk("step_STB", tp_stb, 1); chk("step_PHS", phs, 4'h1);
    nrun = 0;
    while (stopped == 1'b0 && nrun < 100) begin nrun++; tick(); end
    chk("step_len", nrun, 48); chk("step_FS", fs, 3); chk("step_T0", t, 0);

    // MSTP release resumes on the next clock
    go(200); chk("rel_pre", stopped, 1);
    mstp = 0;
    go(201); chk("rel_T", t, 12'h001); chk("rel_STOPPED", stopped, 0); chk("rel_PHS", phs, 4'h1);

    // held restart: requests sampled at 205..207, released at 208
    go(205); goj_req = 1;
    go(206); chk("hold_GOJAM", gojam, 1); chk("hold_T", t, 12'h800);
    go(207); chk("hold_PHS", phs, 4'h1); chk("hold_STB", tp_stb, 1);
    go(208); goj_req = 0; chk("hold_rel_PHS", phs, 4'h1);
    go(211); chk("hold_end_GOJAM", gojam, 1); chk("hold_end_PHS", phs, 4'h8);
    go(212); chk("hold_T01_GOJAM", gojam, 0); chk("hold_T01", t, 12'h001);

    // configuration B: 6 pulses x 3 phases x 2 clocks, 2-bit scaler
    @(posedge clk); #1; rst_b = 1; cyc = 0;
    chk("b_rst_T", t_b, 6'h20); chk("b_rst_PHS", phs_b, 3'h1); chk("b_rst_GOJAM", gojam_b, 1);
    go(5); chk("b_goj_T", t_b, 6'h20); chk("b_goj_GOJAM", gojam_b, 1);
    go(6); chk("b_t01", t_b, 6'h01); chk("b_t01_GOJAM", gojam_b, 0); chk("b_t01_STB", tp_stb_b, 1);
    go(8); chk("b_ovf_pre", ovf_b, 0);
    go(9); chk("b_ovf", ovf_b, 1);
    for (int c = 10; c <= 150; c++) begin
      go(c);
      chk("b_stb", tp_stb_b, ((c - 6) % 6) == 0);
      chk("b_mct", mct_b, ((c - 6) % 36) == 35);
      chk("b_fs", fs_b, ((c - 6) / 36) % 4);
      if (c == 41) begin chk("b_mct_T", t_b, 6'h20); chk("b_mct_PHS", phs_b, 3'h4); end
    end
    chk("b_fs_wrap", fs_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
